ram_1w_nrs_bypass: RTL
======================

RAM_1W_NRS_BYPASS -- requirements
Module: ram_1w_nrs_bypass

Interface
REQ-001 Parameter WORD_COUNT, default 512: number of words; any value >= 2, not necessarily a power of two.
REQ-002 Parameter WORD_WIDTH, default 32: data bits per word.
REQ-003 Parameter MASK_WIDTH, default 4: write-mask lanes; WORD_WIDTH SHALL be a multiple of MASK_WIDTH; lane width LANE = WORD_WIDTH/MASK_WIDTH.
REQ-004 Parameter READ_PORTS, default 2: independent read ports, range 1..4.
REQ-005 Parameter READ_UNDER_WRITE, default RUW_DONT_CARE: one of RUW_DONT_CARE, RUW_READ_FIRST, RUW_WRITE_FIRST.
REQ-006 Parameter OUTPUT_REG, default 0: 1 adds an output register stage per read port.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 wr_en  in  1  write request this cycle.
REQ-010 wr_mask  in  MASK_WIDTH  per-lane write enable.
REQ-011 wr_addr  in  AW  write word address; AW = clog2(WORD_COUNT).
REQ-012 wr_data  in  WORD_WIDTH  write data.
REQ-013 rd_en  in  READ_PORTS  per-port read request.
REQ-014 rd_addr  in  READ_PORTS*AW  port p address at bits [p*AW +: AW].
REQ-015 rd_data  out  READ_PORTS*WORD_WIDTH  port p data at bits [p*WORD_WIDTH +: WORD_WIDTH].
REQ-016 rd_valid  out  READ_PORTS  port p rd_data holds the result of a completed read.

Function
REQ-017 A write SHALL update only the lanes where wr_en=1 and wr_mask[i]=1; other lanes SHALL keep their contents.
REQ-018 A write with wr_addr >= WORD_COUNT SHALL be discarded, with no alias to another address.
REQ-019 A read accepted at edge t (rd_en[p]=1) SHALL present data and rd_valid[p]=1 after the edge at t+1 when OUTPUT_REG=0, and after the edge at t+2 when OUTPUT_REG=1.
REQ-020 Reads SHALL be fully pipelined: one accepted read per port per cycle, with no stalls.
REQ-021 When rd_en[p]=0, rd_data[p] SHALL hold its last value, and rd_valid[p] SHALL drop to 0 after the same latency as REQ-019.
REQ-022 A read with rd_addr >= WORD_COUNT SHALL return all zeros, with rd_valid asserted normally.
REQ-023 Read and write at the same address in the same cycle under RUW_READ_FIRST SHALL return the pre-write word.
REQ-024 Read and write at the same address in the same cycle under RUW_WRITE_FIRST SHALL return, lane by lane, wr_data where wr_mask=1 and the old word elsewhere; this bypass SHALL be evaluated per port.
REQ-025 Read and write at the same address in the same cycle under RUW_DONT_CARE SHALL return an unspecified value, and the write SHALL still complete correctly.
REQ-026 A read one or more cycles after a write SHALL always return the written data, regardless of READ_UNDER_WRITE.
REQ-027 Read ports at the same address SHALL return identical data in the same cycle.
REQ-028 Memory contents SHALL NOT be initialised and SHALL be unspecified until written.

Reset
REQ-029 On reset_n=0, every rd_valid bit and every output and pipeline register SHALL clear to 0 asynchronously; rd_data SHALL read 0.
REQ-030 Reset SHALL NOT alter memory contents, and a write in the same cycle that reset asserts SHALL be discarded.
REQ-031 Reads in flight when reset asserts SHALL be dropped, with no rd_valid pulse after deassertion.
REQ-032 The first read accepted after deassertion SHALL follow REQ-019 exactly.

Structure
REQ-033 A shared package SHALL hold the RUW_* encodings and the clog2 address-width function.
REQ-034 The storage array and write logic SHALL reside in the top level.
REQ-035 A sub-module ram_rd_port SHALL implement one port's collision compare, lane-merge bypass, optional output register and valid pipeline, and SHALL be instantiated READ_PORTS times.

Verification
REQ-036 WORD_WIDTH=32, MASK_WIDTH=4: write 0xAABBCCDD to addr 5 with mask 0xF, then 0x11223344 with mask 0x5; read addr 5 -> 0xAA22CC44 after 1 cycle (OUTPUT_REG=0) and after 2 cycles (OUTPUT_REG=1).
REQ-037 Addr 7 holds 0x0; same-cycle write of 0xDEADBEEF, mask 0x3, plus read on port 0 -> RUW_READ_FIRST returns 0x00000000; RUW_WRITE_FIRST returns 0x0000BEEF; next-cycle read returns 0x0000BEEF in both modes.
REQ-038 READ_PORTS=3: ports 0/1/2 read addresses 1/1/9 every cycle for 16 cycles against known contents -> correct data on every port every cycle, with rd_valid continuously 1.
REQ-039 WORD_COUNT=10: write 0xFFFFFFFF to addr 12, then read addr 2 and addr 12 -> addr 2 is unchanged and addr 12 returns 0.
REQ-040 OUTPUT_REG=1: assert reset_n=0 one cycle after a read is accepted -> rd_valid stays 0 through and after reset; a prior write remains readable afterwards.

Source files
------------

// File: rtl/ram_1w_nrs_bypass_pkg.sv
// ---------------------------------------------------------------------------
// ram_1w_nrs_bypass_pkg
// Shared definitions for the single-write, multi-read RAM:
//   ruw_e       read-under-write behaviour selector
//   addr_width  ceil(log2(count)) with a floor of 1, sizes address buses
// ---------------------------------------------------------------------------
package ram_1w_nrs_bypass_pkg;

  typedef enum logic [1:0] {
    RUW_DONT_CARE   = 2'd0,
    RUW_READ_FIRST  = 2'd1,
    RUW_WRITE_FIRST = 2'd2
  } ruw_e;

  function automatic int addr_width(input int count);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < count) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_1w_nrs_bypass_if.sv
// ---------------------------------------------------------------------------
// ram_1w_nrs_bypass_if
// Bus bundle for ram_1w_nrs_bypass.
//   wr_en/wr_mask/wr_addr/wr_data  one masked write per cycle
//   rd_en/rd_addr                  per-port read request, port p at [p*AW +: AW]
//   rd_data/rd_valid               per-port result, port p at [p*WORD_WIDTH +: WORD_WIDTH]
// master drives requests, slave (the RAM) drives results.
// ---------------------------------------------------------------------------
interface ram_1w_nrs_bypass_if
  import ram_1w_nrs_bypass_pkg::*;
#(
  parameter int WORD_COUNT = 512,
  parameter int WORD_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int READ_PORTS = 2
);
  localparam int AW = addr_width(WORD_COUNT);

  logic                             wr_en;
  logic [MASK_WIDTH-1:0]            wr_mask;
  logic [AW-1:0]                    wr_addr;
  logic [WORD_WIDTH-1:0]            wr_data;
  logic [READ_PORTS-1:0]            rd_en;
  logic [READ_PORTS*AW-1:0]         rd_addr;
  logic [READ_PORTS*WORD_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]            rd_valid;

  modport master (
    output wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/ram_1w_nrs_bypass_rd_port.sv
// ---------------------------------------------------------------------------
// ram_rd_port
// One read port's back end. The raw word arrives from the RAM's registered
// read (always read-first). This block registers the write-collision info
// alongside the read, merges write data lane by lane when write-first is
// selected, zeroes out-of-range reads, and runs the valid pipeline with an
// optional output register.
//   clk, reset_n                   clock, async active-low reset
//   i_rd_en, i_rd_addr             read request for this port
//   i_rd_in_range                  i_rd_addr < WORD_COUNT
//   i_wr_en                        write accepted this cycle (already qualified)
//   i_wr_mask, i_wr_addr, i_wr_data  write payload
//   i_raw_word                     registered memory word for the last read
//   o_rd_data, o_rd_valid          port result
// ---------------------------------------------------------------------------
module ram_rd_port
  import ram_1w_nrs_bypass_pkg::*;
#(
  parameter int   AW               = 9,
  parameter int   WORD_WIDTH       = 32,
  parameter int   MASK_WIDTH       = 4,
  parameter ruw_e READ_UNDER_WRITE = RUW_DONT_CARE,
  parameter bit   OUTPUT_REG       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  input  logic                  i_rd_in_range,
  input  logic                  i_wr_en,
  input  logic [MASK_WIDTH-1:0] i_wr_mask,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [WORD_WIDTH-1:0] i_wr_data,
  input  logic [WORD_WIDTH-1:0] i_raw_word,
  output logic [WORD_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid
);
  localparam int LANE = WORD_WIDTH / MASK_WIDTH;

  logic                  r_valid1;
  logic                  r_in_range;
  logic                  r_hit;
  logic [MASK_WIDTH-1:0] r_byp_mask;
  logic [WORD_WIDTH-1:0] r_byp_data;
  logic                  w_hit;
  logic                  w_use_byp;
  logic [WORD_WIDTH-1:0] w_merged;
  logic [WORD_WIDTH-1:0] w_word;

  assign w_hit = i_wr_en && (i_wr_addr == i_rd_addr);

  // Collision state only moves on an accepted read, so a held result keeps
  // the same merge it was presented with.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid1   <= 1'b0;
      r_in_range <= 1'b0;
      r_hit      <= 1'b0;
      r_byp_mask <= '0;
      r_byp_data <= '0;
    end else begin
      r_valid1 <= i_rd_en;
      if (i_rd_en) begin
        r_in_range <= i_rd_in_range;
        r_hit      <= w_hit;
        r_byp_mask <= i_wr_mask;
        r_byp_data <= i_wr_data;
      end
    end
  end

  assign w_use_byp = (READ_UNDER_WRITE == RUW_WRITE_FIRST) && r_hit;

  for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
    assign w_merged[gi*LANE +: LANE] = (w_use_byp && r_byp_mask[gi])
                                       ? r_byp_data[gi*LANE +: LANE]
                                       : i_raw_word[gi*LANE +: LANE];
  end

  // r_in_range is 0 out of reset, which also forces zero data before the
  // first read even though the raw RAM register is not reset.
  assign w_word = r_in_range ? w_merged : '0;

  if (OUTPUT_REG) begin : g_oreg
    logic                  r_valid2;
    logic [WORD_WIDTH-1:0] r_out_data;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_valid2   <= 1'b0;
        r_out_data <= '0;
      end else begin
        r_valid2 <= r_valid1;
        if (r_valid1) r_out_data <= w_word;
      end
    end

    assign o_rd_data  = r_out_data;
    assign o_rd_valid = r_valid2;
  end else begin : g_noreg
    assign o_rd_data  = w_word;
    assign o_rd_valid = r_valid1;
  end

endmodule

// File: rtl/ram_1w_nrs_bypass.sv
// ---------------------------------------------------------------------------
// ram_1w_nrs_bypass
// Single masked write port, READ_PORTS independent pipelined read ports,
// selectable read-under-write behaviour and optional output register.
//   clk       clock, all state on rising edge
//   reset_n   async active-low reset (clears outputs/pipeline, not memory)
//   bus       ram_1w_nrs_bypass_if.slave: write request, read requests,
//             read data and valid
// Storage is uninitialised. Out-of-range writes are dropped and out-of-range
// reads return zero.
// ---------------------------------------------------------------------------
module ram_1w_nrs_bypass
  import ram_1w_nrs_bypass_pkg::*;
#(
  parameter int   WORD_COUNT       = 512,
  parameter int   WORD_WIDTH       = 32,
  parameter int   MASK_WIDTH       = 4,
  parameter int   READ_PORTS       = 2,
  parameter ruw_e READ_UNDER_WRITE = RUW_DONT_CARE,
  parameter bit   OUTPUT_REG       = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  ram_1w_nrs_bypass_if.slave bus
);
  localparam int            AW   = addr_width(WORD_COUNT);
  localparam int            LANE = WORD_WIDTH / MASK_WIDTH;
  localparam logic [AW:0]   WC   = WORD_COUNT[AW:0];

  logic [WORD_WIDTH-1:0] r_mem [WORD_COUNT];

  logic                                   w_wr_ok;
  logic [READ_PORTS-1:0][WORD_WIDTH-1:0]  w_rd_data;
  logic [READ_PORTS-1:0]                  w_rd_valid;

  // Qualifying with reset_n drops a write whose edge lands while reset is low.
  assign w_wr_ok = bus.wr_en && reset_n && ({1'b0, bus.wr_addr} < WC);

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (bus.wr_mask[i]) r_mem[bus.wr_addr][i*LANE +: LANE] <= bus.wr_data[i*LANE +: LANE];
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_port
    logic [AW-1:0]         w_rd_addr;
    logic                  w_rd_in_range;
    logic [WORD_WIDTH-1:0] r_raw;

    assign w_rd_addr     = bus.rd_addr[gi*AW +: AW];
    assign w_rd_in_range = ({1'b0, w_rd_addr} < WC);

    // Plain registered read: sees the pre-write word on a collision; the
    // port block applies any write-first merge afterwards.
    always_ff @(posedge clk) begin
      if (bus.rd_en[gi] && w_rd_in_range) r_raw <= r_mem[w_rd_addr];
    end

    ram_rd_port #(
      .AW               (AW),
      .WORD_WIDTH       (WORD_WIDTH),
      .MASK_WIDTH       (MASK_WIDTH),
      .READ_UNDER_WRITE (READ_UNDER_WRITE),
      .OUTPUT_REG       (OUTPUT_REG)
    ) u_rd_port (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_rd_en       (bus.rd_en[gi]),
      .i_rd_addr     (w_rd_addr),
      .i_rd_in_range (w_rd_in_range),
      .i_wr_en       (w_wr_ok),
      .i_wr_mask     (bus.wr_mask),
      .i_wr_addr     (bus.wr_addr),
      .i_wr_data     (bus.wr_data),
      .i_raw_word    (r_raw),
      .o_rd_data     (w_rd_data[gi]),
      .o_rd_valid    (w_rd_valid[gi])
    );
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_valid = w_rd_valid;

endmodule
